// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: data-memory access over req/gnt/rvalid, branch/jump redirect,
// and the MEM/WB write-back register. Stalls upstream while a request or load response is pending.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            me_aluOut_WB_memOut,
  input  logic            me_writeReg,
  input  logic [1:0]      me_writeMem,
  input  logic [2:0]      me_readMem,
  input  logic [1:0]      me_pcImm_NEXTPC_rs1Imm,
  input  logic            me_conditionBranch,
  input  logic [XLEN-1:0] me_pcImm,
  input  logic [XLEN-1:0] me_rs1Imm,
  input  logic [XLEN-1:0] me_outAlu,
  input  logic [XLEN-1:0] me_rs2Data,
  input  logic [4:0]      me_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign,
  output logic            wb_writeReg,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic {IDLE, WAIT_R} state_t;

  state_t          state, state_n;
  logic            is_load, is_store, is_half, is_word, misaligned;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_ext;

  assign dmem_addr = {me_outAlu[XLEN-1:2], 2'b00};

  // Load takes priority when both a load and a store are encoded.
  always_comb begin
    is_load    = (me_readMem != 3'b000) && (me_readMem <= 3'b101);
    is_store   = !is_load && (me_writeMem != 2'b00);
    is_half    = (is_load && (me_readMem == 3'b011 || me_readMem == 3'b100)) ||
                 (is_store && me_writeMem == 2'b10);
    is_word    = (is_load && me_readMem == 3'b101) || (is_store && me_writeMem == 2'b11);
    misaligned = (is_half && me_outAlu[0]) || (is_word && me_outAlu[1:0] != 2'b00);
  end

  always_comb begin
    store_be    = 4'b0000;
    store_wdata = '0;
    case (me_writeMem)
      2'b01: begin
        store_be    = 4'b0001 << me_outAlu[1:0];
        store_wdata = {4{me_rs2Data[7:0]}};
      end
      2'b10: begin
        store_be    = me_outAlu[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{me_rs2Data[15:0]}};
      end
      2'b11: begin
        store_be    = 4'b1111;
        store_wdata = me_rs2Data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte  = dmem_rdata[{me_outAlu[1:0], 3'b000} +: 8];
    ld_half  = dmem_rdata[{me_outAlu[1], 4'b0000} +: 16];
    load_ext = dmem_rdata;
    case (me_readMem)
      3'b001:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b010:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b011:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_n    = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    mem_stall  = 1'b0;
    misalign   = 1'b0;
    case (state)
      IDLE: begin
        if (misaligned) begin
          misalign = 1'b1;
        end else if (is_load) begin
          dmem_req  = 1'b1;
          dmem_be   = 4'b1111;
          mem_stall = 1'b1;
          if (dmem_gnt) state_n = WAIT_R;
        end else if (is_store) begin
          dmem_req   = 1'b1;
          dmem_we    = 1'b1;
          dmem_be    = store_be;
          dmem_wdata = store_wdata;
          mem_stall  = !dmem_gnt;
        end
      end
      WAIT_R: begin
        mem_stall = !dmem_rvalid;
        if (dmem_rvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Redirect only once the instruction actually leaves MEM.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (!mem_stall) begin
      if (me_pcImm_NEXTPC_rs1Imm == 2'b01 && (!me_conditionBranch || me_outAlu[0])) begin
        redirect    = 1'b1;
        redirect_pc = me_pcImm;
      end else if (me_pcImm_NEXTPC_rs1Imm == 2'b10) begin
        redirect    = 1'b1;
        redirect_pc = me_rs1Imm & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wb_writeReg <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      state <= state_n;
      if (mem_stall || misalign) begin
        wb_writeReg <= 1'b0;
      end else begin
        wb_writeReg <= me_writeReg;
        wb_rd       <= me_rd;
        wb_data     <= (state == WAIT_R && me_aluOut_WB_memOut) ? load_ext : me_outAlu;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle cases, hand sequences for
// delayed grant, load response latency and reset during an outstanding load.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        me_aluOut_WB_memOut, me_writeReg, me_conditionBranch;
  logic [1:0]  me_writeMem, me_pcImm_NEXTPC_rs1Imm;
  logic [2:0]  me_readMem;
  logic [31:0] me_pcImm, me_rs1Imm, me_outAlu, me_rs2Data;
  logic [4:0]  me_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, redirect, misalign, wb_writeReg;
  logic [31:0] redirect_pc, wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .me_aluOut_WB_memOut(me_aluOut_WB_memOut), .me_writeReg(me_writeReg),
    .me_writeMem(me_writeMem), .me_readMem(me_readMem),
    .me_pcImm_NEXTPC_rs1Imm(me_pcImm_NEXTPC_rs1Imm), .me_conditionBranch(me_conditionBranch),
    .me_pcImm(me_pcImm), .me_rs1Imm(me_rs1Imm), .me_outAlu(me_outAlu),
    .me_rs2Data(me_rs2Data), .me_rd(me_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign(misalign), .wb_writeReg(wb_writeReg),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    string       name;
    logic        mo, wr;
    logic [1:0]  wm;
    logic [2:0]  rm;
    logic [1:0]  nsel;
    logic        cond;
    logic [31:0] pcimm, rs1imm, alu, rs2;
    logic [4:0]  rd;
    logic        gnt, full;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_stall, e_redir;
    logic [31:0] e_rpc;
    logic        e_mis, e_wbw;
    logic [4:0]  e_rd;
    logic [31:0] e_wbd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    me_aluOut_WB_memOut = 0; me_writeReg = 0; me_writeMem = 0; me_readMem = 0;
    me_pcImm_NEXTPC_rs1Imm = 0; me_conditionBranch = 0; me_pcImm = 0; me_rs1Imm = 0;
    me_outAlu = 0; me_rs2Data = 0; me_rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic run_load(input string nm, input logic [2:0] rm, input logic [31:0] exp);
    clear_in();
    me_aluOut_WB_memOut = 1; me_writeReg = 1; me_readMem = rm; me_outAlu = 32'h102;
    me_rd = 5'd9; dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
    #4;
    chk({nm, "_gnt_req"}, {31'd0, dmem_req}, 1);
    chk({nm, "_gnt_be"}, {28'd0, dmem_be}, 4'hF);
    chk({nm, "_gnt_stall"}, {31'd0, mem_stall}, 1);
    chk({nm, "_addr"}, dmem_addr, 32'h100);
    @(posedge clk); #1;
    chk({nm, "_gnt_wbw"}, {31'd0, wb_writeReg}, 0);
    @(negedge clk);
    dmem_gnt = 0; dmem_rvalid = 0;
    for (int c = 0; c < 2; c++) begin
      #4;
      chk({nm, "_wait_req"}, {31'd0, dmem_req}, 0);
      chk({nm, "_wait_stall"}, {31'd0, mem_stall}, 1);
      @(posedge clk); #1;
      chk({nm, "_wait_wbw"}, {31'd0, wb_writeReg}, 0);
      @(negedge clk);
    end
    dmem_rvalid = 1; dmem_rdata = 32'h00800000;
    #4;
    chk({nm, "_rv_stall"}, {31'd0, mem_stall}, 0);
    @(posedge clk); #1;
    chk({nm, "_rv_wbw"}, {31'd0, wb_writeReg}, 1);
    chk({nm, "_rv_rd"}, {27'd0, wb_rd}, 9);
    chk({nm, "_rv_data"}, wb_data, exp);
    @(negedge clk);
    clear_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        name          mo wr wm rm nsel cond pcimm        rs1imm       alu           rs2           rd gnt full | req we be  wdata         stall redir rpc         mis wbw rd wbd
    vecs[0]  = '{"noop",     0, 1, 0, 0, 0, 0, 32'h0,       32'h0,       32'h12345678, 32'h0,        5, 0, 1,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      0, 1, 5, 32'h12345678};
    vecs[1]  = '{"sw",       0, 0, 3, 0, 0, 0, 32'h0,       32'h0,       32'h100,      32'hDEADBEEF, 0, 1, 1,  1, 1, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0,      0, 0, 0, 32'h100};
    vecs[2]  = '{"sh",       0, 0, 2, 0, 0, 0, 32'h0,       32'h0,       32'h102,      32'h0000BEEF, 0, 1, 1,  1, 1, 4'hC, 32'hBEEFBEEF, 0, 0, 32'h0,      0, 0, 0, 32'h102};
    vecs[3]  = '{"sb",       0, 0, 1, 0, 0, 0, 32'h0,       32'h0,       32'h101,      32'h11223344, 0, 1, 1,  1, 1, 4'h2, 32'h44444444, 0, 0, 32'h0,      0, 0, 0, 32'h101};
    vecs[4]  = '{"lh_mis",   1, 1, 0, 3, 0, 0, 32'h0,       32'h0,       32'h101,      32'h0,        7, 1, 0,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      1, 0, 0, 32'h0};
    vecs[5]  = '{"sw_mis",   0, 0, 3, 0, 0, 0, 32'h0,       32'h0,       32'h102,      32'hDEADBEEF, 0, 1, 0,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      1, 0, 0, 32'h0};
    vecs[6]  = '{"beq_t",    0, 0, 0, 0, 1, 1, 32'h40,      32'h0,       32'h1,        32'h0,        0, 0, 1,  0, 0, 4'h0, 32'h0,        0, 1, 32'h40,     0, 0, 0, 32'h1};
    vecs[7]  = '{"beq_nt",   0, 0, 0, 0, 1, 1, 32'h40,      32'h0,       32'h0,        32'h0,        0, 0, 1,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 32'h0};
    vecs[8]  = '{"jal",      0, 1, 0, 0, 1, 0, 32'h80,      32'h0,       32'h104,      32'h0,        1, 0, 1,  0, 0, 4'h0, 32'h0,        0, 1, 32'h80,     0, 1, 1, 32'h104};
    vecs[9]  = '{"jalr",     0, 1, 0, 0, 2, 0, 32'h0,       32'h1235,    32'h208,      32'h0,        1, 0, 1,  0, 0, 4'h0, 32'h0,        0, 1, 32'h1234,   0, 1, 1, 32'h208};
    vecs[10] = '{"sel11",    0, 1, 0, 0, 3, 0, 32'h40,      32'h1235,    32'h10,       32'h0,        2, 0, 1,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      0, 1, 2, 32'h10};
    vecs[11] = '{"ld_st",    1, 1, 3, 5, 2, 0, 32'h0,       32'h1235,    32'h200,      32'h99,       4, 0, 0,  1, 0, 4'hF, 32'h0,        1, 0, 32'h0,      0, 0, 0, 32'h0};
    vecs[12] = '{"rsvd_rm",  1, 1, 0, 6, 0, 0, 32'h0,       32'h0,       32'h33,       32'h0,        6, 0, 1,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      0, 1, 6, 32'h33};
    vecs[13] = '{"lw_mis",   1, 1, 0, 5, 0, 0, 32'h0,       32'h0,       32'h202,      32'h0,        8, 1, 0,  0, 0, 4'h0, 32'h0,        0, 0, 32'h0,      1, 0, 0, 32'h0};

    // Reset must override a live write-back payload.
    clear_in();
    rst_n = 0; me_writeReg = 1; me_rd = 5; me_outAlu = 32'h77;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wbw", {31'd0, wb_writeReg}, 0);
    chk("rst_rd", {27'd0, wb_rd}, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_stall", {31'd0, mem_stall}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
    @(negedge clk);
    rst_n = 1;
    clear_in();

    for (int i = 0; i < 14; i++) begin
      me_aluOut_WB_memOut = vecs[i].mo; me_writeReg = vecs[i].wr; me_writeMem = vecs[i].wm;
      me_readMem = vecs[i].rm; me_pcImm_NEXTPC_rs1Imm = vecs[i].nsel;
      me_conditionBranch = vecs[i].cond; me_pcImm = vecs[i].pcimm; me_rs1Imm = vecs[i].rs1imm;
      me_outAlu = vecs[i].alu; me_rs2Data = vecs[i].rs2; me_rd = vecs[i].rd;
      dmem_gnt = vecs[i].gnt; dmem_rvalid = 0;
      #4;
      chk({vecs[i].name, "_req"}, {31'd0, dmem_req}, {31'd0, vecs[i].e_req});
      chk({vecs[i].name, "_we"}, {31'd0, dmem_we}, {31'd0, vecs[i].e_we});
      chk({vecs[i].name, "_be"}, {28'd0, dmem_be}, {28'd0, vecs[i].e_be});
      chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].e_wdata);
      chk({vecs[i].name, "_stall"}, {31'd0, mem_stall}, {31'd0, vecs[i].e_stall});
      chk({vecs[i].name, "_redir"}, {31'd0, redirect}, {31'd0, vecs[i].e_redir});
      chk({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].e_rpc);
      chk({vecs[i].name, "_mis"}, {31'd0, misalign}, {31'd0, vecs[i].e_mis});
      @(posedge clk); #1;
      chk({vecs[i].name, "_wbw"}, {31'd0, wb_writeReg}, {31'd0, vecs[i].e_wbw});
      if (vecs[i].full) begin
        chk({vecs[i].name, "_wbrd"}, {27'd0, wb_rd}, {27'd0, vecs[i].e_rd});
        chk({vecs[i].name, "_wbdata"}, wb_data, vecs[i].e_wbd);
      end
      @(negedge clk);
    end
    clear_in();

    // sb at 0x103 with grant held off for two cycles.
    me_writeMem = 1; me_rs2Data = 32'hA5; me_outAlu = 32'h103;
    for (int c = 0; c < 3; c++) begin
      dmem_gnt = (c == 2);
      #4;
      chk("sbd_req", {31'd0, dmem_req}, 1);
      chk("sbd_be", {28'd0, dmem_be}, 4'h8);
      chk("sbd_wdata", dmem_wdata, 32'hA5A5A5A5);
      chk("sbd_stall", {31'd0, mem_stall}, (c == 2) ? 0 : 1);
      @(posedge clk); #1;
      chk("sbd_wbw", {31'd0, wb_writeReg}, 0);
      if (c == 2) chk("sbd_wbdata", wb_data, 32'h103);
      @(negedge clk);
    end
    clear_in();

    run_load("lb", 3'b001, 32'hFFFFFF80);
    run_load("lbu", 3'b010, 32'h00000080);

    // lw granted, then reset before the response arrives.
    me_readMem = 3'b101; me_aluOut_WB_memOut = 1; me_writeReg = 1; me_rd = 3;
    me_outAlu = 32'h300; dmem_gnt = 1;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 0; rst_n = 0;
    @(posedge clk); #1;
    chk("rstw_wbw", {31'd0, wb_writeReg}, 0);
    chk("rstw_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1;
    clear_in();
    #4;
    chk("rstw_stall", {31'd0, mem_stall}, 0);
    @(negedge clk);
    me_aluOut_WB_memOut = 1; me_writeReg = 1; me_rd = 3; me_outAlu = 32'h55;
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEBABE;
    #4;
    chk("rstw_rv_stall", {31'd0, mem_stall}, 0);
    @(posedge clk); #1;
    chk("rstw_rv_wbw", {31'd0, wb_writeReg}, 1);
    chk("rstw_rv_data", wb_data, 32'h55);
    @(negedge clk);
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
